// File: rtl/mem_arbiter_dados_pkg.sv
// Shared constants and types for the two-port data-memory arbiter.
package mem_arbiter_dados_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED0  = 2'd1,
    LOCKED1  = 2'd2
  } lock_state_e;
endpackage

// File: rtl/mem_arbiter_dados_rr_arbiter2.sv
// Two-way round-robin arbiter with an ownership mask; grant is combinational,
// the last-served requester is registered.
module rr_arbiter2
  import mem_arbiter_dados_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       lock_valid,
  input  logic       lock_owner,
  output logic [1:0] gnt
);

  logic last_reg;

  always_comb begin
    gnt = 2'b00;
    if (!rst_n) begin
      gnt = 2'b00;
    end else if (lock_valid) begin
      if (lock_owner == OWN_M1) gnt = {req[1], 1'b0};
      else                      gnt = {1'b0, req[0]};
    end else if (req == 2'b11) begin
      // On conflict, favour whoever was not served last.
      gnt = (last_reg == OWN_M0) ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       last_reg <= OWN_M1;
    else if (gnt[1])  last_reg <= OWN_M1;
    else if (gnt[0])  last_reg <= OWN_M0;
  end

endmodule

// File: rtl/mem_arbiter_dados.sv
// Arbiter/sequencer sharing the single-port data memory between the CPU (m0)
// and the I/O engine (m1) with a one-cycle req/gnt/rvalid protocol.
module mem_arbiter_dados
  import mem_arbiter_dados_pkg::*;
#(
  parameter int RAM_SIZE = 500,
  parameter int AW       = ADDR_W,
  parameter int DW       = DATA_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_lock,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_lock,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_datain,
  input  logic [DW-1:0] mem_dataout
);

  lock_state_e   lock_state_reg;
  logic          mem_we_reg;
  logic [AW-1:0] mem_addr_reg;
  logic [DW-1:0] mem_datain_reg;
  logic          resp_valid_reg;
  logic          resp_owner_reg;
  logic          resp_err_reg;

  logic [1:0]    gnt;
  logic          accept;
  logic          sel;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          in_range;

  rr_arbiter2 u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        ({m1_req, m0_req}),
    .lock_valid (lock_state_reg != UNLOCKED),
    .lock_owner (lock_state_reg == LOCKED1),
    .gnt        (gnt)
  );

  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];
  assign accept    = |gnt;
  assign sel       = gnt[1];
  assign sel_we    = sel ? m1_we    : m0_we;
  assign sel_addr  = sel ? m1_addr  : m0_addr;
  assign sel_wdata = sel ? m1_wdata : m0_wdata;
  assign in_range  = sel_addr < AW'(RAM_SIZE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_state_reg <= UNLOCKED;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_datain_reg <= '0;
      resp_valid_reg <= 1'b0;
      resp_owner_reg <= OWN_M0;
      resp_err_reg   <= 1'b0;
    end else begin
      resp_valid_reg <= accept;
      if (accept) begin
        mem_addr_reg   <= sel_addr;
        mem_datain_reg <= sel_wdata;
        mem_we_reg     <= sel_we & in_range;
        resp_owner_reg <= sel;
        resp_err_reg   <= ~in_range;
      end else begin
        mem_we_reg     <= 1'b0;
        resp_err_reg   <= 1'b0;
      end
      case (lock_state_reg)
        UNLOCKED: begin
          if (gnt[0] && m0_lock)      lock_state_reg <= LOCKED0;
          else if (gnt[1] && m1_lock) lock_state_reg <= LOCKED1;
        end
        LOCKED0: if (!m0_lock) lock_state_reg <= UNLOCKED;
        LOCKED1: if (!m1_lock) lock_state_reg <= UNLOCKED;
        default: lock_state_reg <= UNLOCKED;
      endcase
    end
  end

  assign mem_we     = mem_we_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_datain = mem_datain_reg;

  // Memory read data lands at the negedge; it is steered straight through.
  assign m0_rvalid = resp_valid_reg && (resp_owner_reg == OWN_M0);
  assign m1_rvalid = resp_valid_reg && (resp_owner_reg == OWN_M1);
  assign m0_err    = m0_rvalid & resp_err_reg;
  assign m1_err    = m1_rvalid & resp_err_reg;
  assign m0_rdata  = (m0_rvalid && !resp_err_reg) ? mem_dataout : '0;
  assign m1_rdata  = (m1_rvalid && !resp_err_reg) ? mem_dataout : '0;

endmodule

// File: tb/tb_mem_arbiter_dados.sv
// Scoreboard bench for mem_arbiter_dados with a behavioural negedge-read memory.
module tb_mem_arbiter_dados;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 0, m0_we = 0, m0_lock = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0;
  logic        m1_req = 0, m1_we = 0, m1_lock = 0;
  logic [31:0] m1_addr = 0, m1_wdata = 0;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_datain;
  logic [31:0] mem_dataout = 0;

  logic [31:0] mem_model [0:499];

  typedef struct {
    bit          owner;
    bit          we;
    bit          err;
    logic [31:0] rdata;
    int          due;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  mem_arbiter_dados #(.RAM_SIZE(500), .AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_datain(mem_datain),
    .mem_dataout(mem_dataout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: write on posedge, registered read on negedge.
  always @(posedge clk)
    if (mem_we && mem_addr < 32'd500) mem_model[mem_addr[8:0]] <= mem_datain;
  always @(negedge clk)
    mem_dataout <= (mem_addr < 32'd500) ? mem_model[mem_addr[8:0]] : 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input bit r0, input bit w0, input bit l0,
                      input logic [31:0] a0, input logic [31:0] d0,
                      input bit r1, input bit w1, input bit l1,
                      input logic [31:0] a1, input logic [31:0] d1,
                      input logic [1:0] eg, input logic [31:0] erd,
                      input string tag);
    exp_t e;
    @(posedge clk); #1;
    m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
    #3;
    chk({tag, " gnt"}, {30'd0, m1_gnt, m0_gnt}, {30'd0, eg});
    if (eg[0]) begin
      e.owner = 1'b0; e.we = w0; e.err = (a0 >= 32'd500); e.rdata = erd; e.due = cyc + 1;
      sb.push_back(e);
    end
    if (eg[1]) begin
      e.owner = 1'b1; e.we = w1; e.err = (a1 >= 32'd500); e.rdata = erd; e.due = cyc + 1;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, "idle");
  endtask

  // Monitor: pops one expectation whenever a response cycle is presented.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (m0_rvalid || m1_rvalid) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_rvalid: got rvalid=%b%b expected none", m1_rvalid, m0_rvalid);
        end else begin
          e = sb.pop_front();
          $display("resp cycle=%0d owner=m%0d we=%0d err=%b%b rdata=%h/%h",
                   cyc, e.owner, e.we, m1_err, m0_err, m1_rdata, m0_rdata);
          chk("rvalid_onehot", {31'd0, m0_rvalid & m1_rvalid}, 32'd0);
          chk("resp_latency", 32'(cyc), 32'(e.due));
          chk("resp_owner", {31'd0, m1_rvalid}, {31'd0, e.owner});
          chk("resp_err", {31'd0, e.owner ? m1_err : m0_err}, {31'd0, e.err});
          chk("resp_mem_we", {31'd0, mem_we}, {31'd0, e.we & ~e.err});
          if (!e.we) chk("resp_rdata", e.owner ? m1_rdata : m0_rdata, e.err ? 32'd0 : e.rdata);
          chk("nonowner_rdata", e.owner ? m0_rdata : m1_rdata, 32'd0);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 500; i++) mem_model[i] = 32'd0;
    mem_model[3] = 32'h100;
    mem_model[7] = 32'h55;

    // Reset state
    @(posedge clk); #2;
    chk("rst_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_datain", mem_datain, 32'd0);
    chk("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    chk("rst_err", {30'd0, m1_err, m0_err}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // m0 write then back-to-back read
    step(1, 1, 0, 10, 32'hDEADBEEF, 0, 0, 0, 0, 0, 2'b01, 0, "m0_wr10");
    step(1, 0, 0, 10, 0,            0, 0, 0, 0, 0, 2'b01, 32'hDEADBEEF, "m0_rd10");
    idle();

    // m1 boundary addresses
    step(0, 0, 0, 0, 0, 1, 1, 0, 499, 32'h5, 2'b10, 0, "m1_wr499");
    step(0, 0, 0, 0, 0, 1, 1, 0, 500, 32'h7, 2'b10, 0, "m1_wr500");
    step(0, 0, 0, 0, 0, 1, 0, 0, 499, 0,     2'b10, 32'h5, "m1_rd499");
    step(0, 0, 0, 0, 0, 1, 0, 0, 32'hFFFF_FFFF, 0, 2'b10, 0, "m1_rdmax");
    idle();

    // Contention: grants alternate starting with m0
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) step(1, 0, 0, 10, 0, 1, 0, 0, 499, 0, 2'b01, 32'hDEADBEEF, "rr_m0");
      else            step(1, 0, 0, 10, 0, 1, 0, 0, 499, 0, 2'b10, 32'h5, "rr_m1");
    end
    idle();

    // Locked read-modify-write by m0 while m1 requests continuously
    step(1, 0, 1, 3, 0,      1, 0, 0, 499, 0, 2'b01, 32'h100, "lk_rd3");
    step(0, 0, 1, 0, 0,      1, 0, 1, 499, 0, 2'b00, 0, "lk_hold");
    step(1, 1, 1, 3, 32'h101, 1, 0, 1, 499, 0, 2'b01, 0, "lk_wr3");
    step(0, 0, 0, 0, 0,      1, 0, 0, 499, 0, 2'b00, 0, "lk_drop");
    step(0, 0, 0, 0, 0,      1, 0, 0, 499, 0, 2'b10, 32'h5, "lk_m1");
    idle();
    step(1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 2'b01, 32'h101, "rd3_after_rmw");

    // Read-after-write on the same address
    step(1, 1, 0, 20, 32'h1234, 0, 0, 0, 0, 0, 2'b01, 0, "raw_wr20");
    step(1, 0, 0, 20, 0,        0, 0, 0, 0, 0, 2'b01, 32'h1234, "raw_rd20");
    idle();

    // Reset during the response cycle of a write drops it
    step(1, 1, 0, 7, 32'hAA, 0, 0, 0, 0, 0, 2'b01, 0, "rst_wr7");
    void'(sb.pop_back());
    @(posedge clk); #2;
    rst_n = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    #1;
    chk("rstmid_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rstmid_rvalid", {31'd0, m0_rvalid}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    chk("mem7_kept", mem_model[7], 32'h55);
    step(1, 0, 0, 7, 0, 1, 0, 0, 10, 0, 2'b01, 32'h55, "post_rst_m0");
    step(0, 0, 0, 0, 0, 1, 0, 0, 10, 0, 2'b10, 32'hDEADBEEF, "post_rst_m1");
    idle();
    idle();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("mem3_once", mem_model[3], 32'h101);
    chk("mem499", mem_model[499], 32'h5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_dados.md
Name: mem_arbiter_dados

Overview:
- Two-port arbiter and sequencer in front of the single-port data memory (word-addressed; write on posedge; read data registered on negedge).
- Shares the memory between requester 0 (CPU datapath) and requester 1 (I/O/DMA engine).
- Uses round-robin arbitration, an optional bus lock for read-modify-write, and an address range check.
- Converts the memory's half-cycle read timing into a clean one-cycle req/gnt/rvalid protocol.

Parameters:
- RAM_SIZE, 500, number of 32-bit words in the data memory; legal addresses are 0..RAM_SIZE-1.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- m0_req  in  1  requester 0 transaction request; held until granted.
- m0_we  in  1  requester 0: 1 = write, 0 = read.
- m0_addr  in  AW  requester 0 word address.
- m0_wdata  in  DW  requester 0 write data.
- m0_lock  in  1  requester 0 keeps ownership after its grant while high.
- m0_gnt  out  1  request accepted this cycle (combinational).
- m0_rvalid  out  1  response cycle for requester 0's accepted transaction.
- m0_rdata  out  DW  read data; valid by the posedge ending the rvalid cycle.
- m0_err  out  1  address out of range; qualified by m0_rvalid.
- m1_req, m1_we, m1_addr, m1_wdata, m1_lock, m1_gnt, m1_rvalid, m1_rdata, m1_err: same as the m0_* ports, for requester 1.
- mem_we  out  1  to memory we.
- mem_addr  out  AW  to memory addr.
- mem_datain  out  DW  to memory datain.
- mem_dataout  in  DW  from memory dataout.

Behaviour:
- Reset (async, rst_n=0):
  - mem_we=0, mem_addr=0, mem_datain=0, all rvalid/err=0, all gnt=0.
  - owner=NONE, last=1 (so requester 0 wins the first conflict).
  - A transaction registered but not yet committed is dropped: no write, no response.
- Arbitration (combinational, from registered state):
  - If owner locked to x: only x may be granted; the other requester's gnt=0.
  - Else if exactly one req: grant it.
  - Else if both req: grant the requester that is not `last`.
  - gnt_x is never asserted without req_x.
  - At most one gnt per cycle.
- Acceptance at posedge with req_x & gnt_x:
  - Register mem_addr<=addr_x and mem_datain<=wdata_x.
  - Register mem_we <= we_x & (addr_x < RAM_SIZE).
  - Register resp_owner<=x, resp_err<=(addr_x >= RAM_SIZE), last<=x.
  - Lock state:
    - If lock_x: state LOCKED(x), entered on the first accepted transaction with lock_x=1.
    - Deassertion of lock_x in any cycle returns to UNLOCKED at the next posedge.
  - If no acceptance: mem_we<=0; mem_addr and mem_datain hold.
- Response:
  - rvalid_x=1 in the cycle after acceptance (latency 1); m{x}_err = resp_err in that cycle.
  - Write: the memory commits at the posedge ending the response cycle.
  - Read: rdata_x = mem_dataout, or 0 if resp_err. Valid from the negedge mid-cycle; the requester samples at the closing posedge.
  - rdata of the non-owner = 0.
- Throughput: back-to-back acceptance is allowed (one transaction per cycle). Fixed 1-cycle response latency; responses are in order.
- Read-after-write, same address, back-to-back: the read is accepted at edge T+1 while the write commits at edge T+1. The memory negedge read in cycle T+2 returns the new data, so no hazard. This must be verified.
- Boundaries:
  - addr=RAM_SIZE-1 is legal.
  - addr=RAM_SIZE and any larger 32-bit value raise err; no write is issued.
  - Both locks asserted: the current owner retains ownership; the other waits.
  - Lock asserted while not granted has no effect.
- FSM states: UNLOCKED, LOCKED0, LOCKED1. Response pipeline: one stage (resp_valid, resp_owner, resp_err).

Decomposition:
- Shared package: DATA_W/ADDR_W constants; owner encoding (OWN_M0=0, OWN_M1=1); lock-state enum.
- One natural sub-module: rr_arbiter2 (2-way round-robin with lock mask, combinational grant plus `last` register).

Test Plan:
- Reset, then m0 writes 0xDEADBEEF to addr 10, then m0 reads addr 10 -> gnt same cycle as each req; m0_rvalid one cycle later; read returns 0xDEADBEEF with err=0.
- m0 and m1 both req reads every cycle for 6 cycles -> grants alternate m0,m1,m0,m1,m0,m1; each rvalid arrives exactly 1 cycle after its gnt, with the correct owner.
- m1 write addr 499 data 0x5, then addr 500 data 0x7, then read 499 -> first write has err=0; second has m1_err=1 and mem_we=0; read returns 0x5.
- m0 asserts lock, does read addr 3 then write addr 3 (value+1) while m1 reqs continuously -> m1_gnt=0 until m0_lock drops; m1 is granted the next cycle; mem[3] is incremented exactly once.
- Back-to-back m0 write addr 20 = 0x1234 then read addr 20 -> read returns 0x1234.
- Assert rst_n=0 mid-cycle after acceptance of a write to addr 7 = 0xAA (mem[7] preloaded 0x55) -> mem_we drops immediately; no rvalid; mem[7] stays 0x55; after release, the first conflict grants m0.
